// File: rtl/uart_mult_responder.sv
// UART-side command responder: collects operand bytes A and B from the UART
// receiver, launches one multiply, and returns the 16-bit product big-endian
// as two bytes through the UART transmitter handshake.
module uart_mult_responder #(
    parameter int OPERAND_W      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_int,
    input  logic                   uart_reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [OPERAND_W-1:0]   mult_a,
    output logic [OPERAND_W-1:0]   mult_b,
    output logic                   mult_start,
    input  logic                   mult_done,
    input  logic [2*OPERAND_W-1:0] mult_result,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_B,
        LAUNCH,
        MWAIT,
        TX_HI,
        TX_HI_W,
        TX_LO,
        TX_LO_W
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OPERAND_W-1:0]     a_q, a_d;
    logic [OPERAND_W-1:0]     b_q, b_d;
    logic [2*OPERAND_W-1:0]   res_q, res_d;
    logic                     mult_start_q, mult_start_d;
    logic                     overrun_q, overrun_d;

    // Control state, operands and registered strobes; reset aborts any transaction.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mult_start_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mult_start_q <= mult_start_d;
            overrun_q    <= overrun_d;
        end
    end

    // Product holding register; only read while the FSM is in a TX state.
    always_ff @(posedge clk_int) begin
        res_q <= res_d;
    end

    // Next-state logic and Moore/Mealy outputs of the command FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        frame_err    = 1'b0;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        // mult_start is registered off LAUNCH so it lands two cycles after byte B.
        mult_start_d = (state_q == LAUNCH);
        // Bytes arriving while a multiply/response is in flight are dropped and flagged.
        overrun_d    = rx_valid && (state_q != IDLE) && (state_q != WAIT_B);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    a_d     = rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the timeout cycle takes priority over the timeout.
                if (rx_valid) begin
                    b_d     = rx_data;
                    state_d = LAUNCH;
                end else if (cnt_q == CNT_LAST) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LAUNCH: begin
                // A result arriving this early is still captured.
                if (mult_done) begin
                    res_d   = mult_result;
                    state_d = TX_HI;
                end else begin
                    state_d = MWAIT;
                end
            end
            MWAIT: begin
                if (mult_done) begin
                    res_d   = mult_result;
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                tx_start = 1'b1;
                tx_data  = res_q[2*OPERAND_W-1:OPERAND_W];
                if (!tx_ready) state_d = TX_HI_W;
            end
            TX_HI_W: begin
                tx_data = res_q[2*OPERAND_W-1:OPERAND_W];
                if (tx_ready) state_d = TX_LO;
            end
            TX_LO: begin
                tx_start = 1'b1;
                tx_data  = res_q[OPERAND_W-1:0];
                if (!tx_ready) state_d = TX_LO_W;
            end
            TX_LO_W: begin
                tx_data = res_q[OPERAND_W-1:0];
                if (tx_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign mult_start = mult_start_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
